// File: rtl/alsu_disp_pkg.sv
// ---------------------------------------------------------------------------
// alsu_disp_pkg
// Shared definitions for the ALSU result display:
//   - conv_state_e : states of the sequential binary-to-BCD converter
//   - SEG_*        : active-low {g,f,e,d,c,b,a} segment patterns
//   - seg_decode() : 0..9 nibble to segment pattern (anything else is blank)
//   - DIGITS       : number of multiplexed display digits
// ---------------------------------------------------------------------------
package alsu_disp_pkg;

  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/alsu_result_display_if.sv
// ---------------------------------------------------------------------------
// alsu_result_display_if
// Bundles the ALSU-facing inputs and the display-facing outputs.
//   alsu_out  [5:0]  ALSU result (unsigned)
//   alsu_leds [15:0] ALSU LED bus, nonzero = invalid-operation indication
//   seg       [6:0]  segment cathodes {g,f,e,d,c,b,a}, active-low
//   dp               decimal point, active-low
//   an        [3:0]  one-hot active-low anodes, an[0] = ones digit
//   bcd_out   [7:0]  last converted value {tens,ones}
//   busy             conversion in progress
//   err              registered (alsu_leds != 0)
//   dbg_state        converter FSM state, for observation only
// Modports: master = ALSU side / observer, slave = the display block.
//
// Result handshake: there is no valid/ready pair. busy rises on the edge
// that loads a new value and falls on the same edge that writes bcd_out,
// so a 1->0 transition of busy marks a freshly valid bcd_out. Inputs are
// sampled every cycle and never stalled; a change seen while busy is
// picked up by a fresh conversion right after the current one ends.
// ---------------------------------------------------------------------------
interface alsu_result_display_if;
  import alsu_disp_pkg::*;

  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [7:0]  bcd_out;
  logic        busy;
  logic        err;
  conv_state_e dbg_state;

  modport master (
    output alsu_out, alsu_leds,
    input  seg, dp, an, bcd_out, busy, err, dbg_state
  );

  modport slave (
    input  alsu_out, alsu_leds,
    output seg, dp, an, bcd_out, busy, err, dbg_state
  );

endinterface

// File: rtl/alsu_result_display_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, 6-bit binary to 2-digit BCD.
//   clk, rst     clock, asynchronous active-low reset
//   start        request; accepted only in IDLE
//   in_val [5:0] value loaded when start is accepted
//   busy         high from load edge until the edge that writes bcd
//   bcd    [7:0] last completed conversion {tens,ones}
//   state        current FSM state (debug)
// Sequence: IDLE -> SHIFT (6 cycles) -> DONE -> IDLE.
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import alsu_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  in_val,
  output logic        busy,
  output logic [7:0]  bcd,
  output conv_state_e state
);

  // {tens[13:10], ones[9:6], binary[5:0]}
  conv_state_e state_q, state_d;
  logic [13:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [13:0] sr_adj;

  // Nibble correction applied before each shift so no digit exceeds 9.
  always_comb begin
    sr_adj = sr_q;
    if (sr_q[13:10] >= 4'd5) sr_adj[13:10] = sr_q[13:10] + 4'd3;
    if (sr_q[9:6]   >= 4'd5) sr_adj[9:6]   = sr_q[9:6]   + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {8'b0, in_val};
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = {sr_adj[12:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = sr_q[13:6];
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sr_q    <= 14'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      bcd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy  = busy_q;
  assign bcd   = bcd_q;
  assign state = state_q;

endmodule

// File: rtl/alsu_result_display.sv
// ---------------------------------------------------------------------------
// alsu_result_display
// Samples the ALSU result and LED bus, converts the result to BCD with a
// sequential converter and drives a 4-digit multiplexed 7-segment display.
// A nonzero LED bus shows "Err" instead of the value.
// Parameters:
//   REFRESH_DIV  cycles each digit stays active (>= 1)
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   alsu_result_display_if.slave (alsu_out, alsu_leds in;
//         seg, dp, an, bcd_out, busy, err, dbg_state out)
// Build option:
//   DISP_LEADING_ZERO_BLANK_EN  when defined, a zero tens digit is blanked.
// ---------------------------------------------------------------------------
module alsu_result_display
  import alsu_disp_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input logic                   clk,
  input logic                   rst,
  alsu_result_display_if.slave  bus
);

  localparam logic [15:0] CNT_MAX = REFRESH_DIV - 16'd1;

  logic [5:0]        in_q, in_d;
  logic              err_q, err_d;
  logic [5:0]        last_val_q, last_val_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              dp_q, dp_d;

  logic              conv_start;
  logic              conv_busy;
  logic [7:0]        conv_bcd;
  conv_state_e       conv_state;
  logic [6:0]        tens_seg;

  // Any difference from the last loaded value requests a conversion; the
  // converter only takes it in IDLE, so a change during a conversion is
  // served right after it completes.
  assign conv_start = (in_q != last_val_q);

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .in_val (in_q),
    .busy   (conv_busy),
    .bcd    (conv_bcd),
    .state  (conv_state)
  );

  always_comb begin
    in_d       = bus.alsu_out;
    err_d      = |bus.alsu_leds;
    last_val_d = last_val_q;
    if (conv_start && conv_state == ST_IDLE) last_val_d = in_q;
  end

  always_comb begin
`ifdef DISP_LEADING_ZERO_BLANK_EN
    tens_seg = (conv_bcd[7:4] == 4'd0) ? SEG_BLANK : seg_decode(conv_bcd[7:4]);
`else
    tens_seg = seg_decode(conv_bcd[7:4]);
`endif
  end

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (cnt_q >= CNT_MAX) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end

    case (idx_q)
      2'd0:    seg_d = err_q ? SEG_BLANK : seg_decode(conv_bcd[3:0]);
      2'd1:    seg_d = err_q ? SEG_R     : tens_seg;
      2'd2:    seg_d = err_q ? SEG_R     : SEG_BLANK;
      default: seg_d = err_q ? SEG_E     : SEG_BLANK;
    endcase

    an_d = ~(4'b0001 << idx_q);
    // Decimal point on the ones digit doubles as a "converting" indicator.
    dp_d = ~(conv_busy && (idx_q == 2'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q       <= 6'd0;
      err_q      <= 1'b0;
      last_val_q <= 6'd0;
      cnt_q      <= 16'd0;
      idx_q      <= 2'd0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
      dp_q       <= 1'b1;
    end else begin
      in_q       <= in_d;
      err_q      <= err_d;
      last_val_q <= last_val_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp        = dp_q;
  assign bus.bcd_out   = conv_bcd;
  assign bus.busy      = conv_busy;
  assign bus.err       = err_q;
  assign bus.dbg_state = conv_state;

endmodule

// File: tb/tb_alsu_result_display.sv
// ---------------------------------------------------------------------------
// tb_alsu_result_display
// Two instances: dut_a with REFRESH_DIV=4 (main traffic), dut_b with
// REFRESH_DIV=1 (scan rate only). Completed conversions are checked by a
// monitor against an expected queue; display content is checked directly.
// ---------------------------------------------------------------------------
module tb_alsu_result_display;

  logic clk;
  logic rst;

  alsu_result_display_if bus_a ();
  alsu_result_display_if bus_b ();

  alsu_result_display #(.REFRESH_DIV(16'd4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  alsu_result_display #(.REFRESH_DIV(16'd1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

`ifdef DISP_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] EXP_TENS_ZERO = 7'h7F;
`else
  localparam logic [6:0] EXP_TENS_ZERO = 7'h40;
`endif

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_val(input logic [5:0] v);
    @(posedge clk);
    #1 bus_a.alsu_out = v;
  endtask

  task automatic drive_leds(input logic [15:0] v);
    @(posedge clk);
    #1 bus_a.alsu_leds = v;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!bus_a.busy && exp_q.size() == 0) return;
    end
    timeout(name);
  endtask

  task automatic check_digit(input string name, input logic [3:0] an_t, input logic [6:0] exp);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus_a.an == an_t) begin
        chk(name, {25'd0, bus_a.seg}, {25'd0, exp});
        return;
      end
    end
    timeout(name);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic       prev_busy;
    int         busy_len;
    logic [7:0] e;
    prev_busy = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_busy = 1'b0;
        busy_len  = 0;
      end else if (bus_a.busy) begin
        prev_busy = 1'b1;
        busy_len++;
      end else if (prev_busy) begin
        prev_busy = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %0h expected none", bus_a.bcd_out);
        end else begin
          e = exp_q.pop_front();
          chk("bcd_out", {24'd0, bus_a.bcd_out}, {24'd0, e});
          chk("busy_len", busy_len, 7);
        end
        busy_len = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] an_seq [4];
  logic [3:0] prev_an;
  logic       found;

  initial begin
    an_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
    rst = 1'b0;
    bus_a.alsu_out = 6'd0;  bus_a.alsu_leds = 16'h0;
    bus_b.alsu_out = 6'd0;  bus_b.alsu_leds = 16'h0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_seg", {25'd0, bus_a.seg}, 32'h7F);
    chk("rst_an", {28'd0, bus_a.an}, 32'hF);
    chk("rst_dp", {31'd0, bus_a.dp}, 32'd1);
    chk("rst_bcd", {24'd0, bus_a.bcd_out}, 32'h00);
    chk("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    chk("rst_err", {31'd0, bus_a.err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);

    // 49 -> tens 4, ones 9
    drive_val(6'd49);
    exp_q.push_back(8'h49);
    @(posedge clk);                       // edge k: sampled
    @(posedge clk);                       // edge k+1: loaded
    #1 chk("busy_k1", {31'd0, bus_a.busy}, 32'd1);
    wait_idle("idle_49");
    repeat (2) @(posedge clk);
    check_digit("d0_49", 4'hE, 7'h10);
    check_digit("d1_49", 4'hD, 7'h19);
    check_digit("d2_49", 4'hB, 7'h7F);
    check_digit("d3_49", 4'h7, 7'h7F);

    // 5 -> leading-zero handling
    drive_val(6'd5);
    exp_q.push_back(8'h05);
    wait_idle("idle_5");
    repeat (2) @(posedge clk);
    check_digit("d0_5", 4'hE, 7'h12);
    check_digit("d1_5", 4'hD, EXP_TENS_ZERO);

    // error display
    drive_leds(16'hFFFF);
    @(posedge clk);
    #1 chk("err_set", {31'd0, bus_a.err}, 32'd1);
    repeat (2) @(posedge clk);
    check_digit("err_d3", 4'h7, 7'h06);
    check_digit("err_d2", 4'hB, 7'h2F);
    check_digit("err_d1", 4'hD, 7'h2F);
    check_digit("err_d0", 4'hE, 7'h7F);
    drive_leds(16'h0000);
    @(posedge clk);
    #1 chk("err_clr", {31'd0, bus_a.err}, 32'd0);
    repeat (2) @(posedge clk);
    check_digit("ret_d0", 4'hE, 7'h12);
    check_digit("ret_d1", 4'hD, EXP_TENS_ZERO);

    // input change during conversion: 10 completes, then 20
    drive_val(6'd10);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    repeat (3) @(posedge clk);
    #1 bus_a.alsu_out = 6'd20;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!bus_a.busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout("first_done");
    else begin
      chk("first_bcd", {24'd0, bus_a.bcd_out}, 32'h10);
      @(posedge clk);
      #1 chk("restart_busy", {31'd0, bus_a.busy}, 32'd1);
    end
    wait_idle("idle_20");
    chk("final_bcd", {24'd0, bus_a.bcd_out}, 32'h20);

    // reset in the middle of a conversion
    drive_val(6'd33);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_seg", {25'd0, bus_a.seg}, 32'h7F);
    chk("mid_rst_an", {28'd0, bus_a.an}, 32'hF);
    chk("mid_rst_busy", {31'd0, bus_a.busy}, 32'd0);
    chk("mid_rst_bcd", {24'd0, bus_a.bcd_out}, 32'h00);
    repeat (2) @(negedge clk);
    chk("hold_rst_bcd", {24'd0, bus_a.bcd_out}, 32'h00);
    chk("hold_rst_an", {28'd0, bus_a.an}, 32'hF);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(8'h33);
    wait_idle("idle_33");

    // scan sequence, REFRESH_DIV=4
    found = 1'b0;
    prev_an = bus_a.an;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus_a.an == 4'hE && prev_an != 4'hE) begin
        found = 1'b1;
        break;
      end
      prev_an = bus_a.an;
    end
    if (!found) timeout("scan_a_align");
    else begin
      chk("dp_idle", {31'd0, bus_a.dp}, 32'd1);
      for (int i = 1; i <= 16; i++) begin
        @(negedge clk);
        chk("scan_a", {28'd0, bus_a.an}, {28'd0, an_seq[(i / 4) % 4]});
      end
    end

    // scan sequence, REFRESH_DIV=1
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_b.an == 4'hE) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout("scan_b_align");
    else begin
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        chk("scan_b", {28'd0, bus_b.an}, {28'd0, an_seq[i % 4]});
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
